lcd_sync_gen: RTL and testbench
===============================

# lcd_sync_gen

Video timing transmitter driving the HS/VS line-valid/frame-valid pair that the LCD counter and window logic consume. It free-runs a pixel/line raster from parameterised active and blanking sizes, starts and stops only on frame boundaries, and emits aligned DE, pixel coordinates and a frame-start strobe. It sits at the source end of the display path, ahead of any overlay or window logic keyed to the rising edges of HS and VS.

## Interface
- H_ACT, 800, active pixels per line
- H_BLK, 160, blanking pixels per line, minimum 1
- V_ACT, 480, active lines per frame
- V_BLK, 45, blanking lines per frame, minimum 1
- CLK  in  1  pixel clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- EN  in  1  run request; sampled every cycle, acted on only at frame boundaries
- HS  out  1  line valid; high for H_ACT cycles of every line, including vertical-blank lines
- VS  out  1  frame valid; high for all cycles of lines 0..V_ACT-1
- DE  out  1  HS & VS
- X  out  12  pixel position in line, 0..H_ACT+H_BLK-1
- Y  out  12  line position in frame, 0..V_ACT+V_BLK-1
- FRAME_START  out  1  one-cycle pulse on the first active pixel (X=0, Y=0)
- PIX  out  24  RGB888 test pattern, {R,G,B}; see Configuration

## Operation
- H_TOT = H_ACT+H_BLK, V_TOT = V_ACT+V_BLK; both must be ≤ 4096. Internal h/v counters are 12-bit unsigned; no arithmetic exceeds 12 bits.
- States: IDLE, RUN.
- IDLE: h=v=0; HS, VS, DE, FRAME_START, PIX = 0; X=Y=0. EN=1 sampled → RUN next cycle, starting at h=0, v=0.
- RUN: h increments every cycle; at h=H_TOT-1, h wraps to 0 and v increments; at v=V_TOT-1 with h=H_TOT-1, v wraps to 0.
- Outputs decoded from h/v and registered together, so all outputs are mutually aligned: X=h, Y=v, HS=(h<H_ACT), VS=(v<V_ACT), DE=HS&VS, FRAME_START=(h==0 && v==0).
- HS rises at h=0; VS rises in the same cycle as the line-0 HS rise, so a downstream edge-detecting counter resets both H and V counts on the same edge.
- Stop: the frame end is the cycle with h=H_TOT-1, v=V_TOT-1. If EN=0 in that cycle → IDLE next cycle, all outputs 0. If EN=1 in that cycle → the next frame starts with no gap. EN toggling mid-frame has no effect; only its value at the frame end matters.
- Reset, including reset mid-frame: all outputs 0 immediately and asynchronously; state IDLE; no partial frame is resumed after release.

## Timing
- EN high sampled in IDLE at cycle t → cycle t+1 shows HS=VS=DE=FRAME_START=1, X=Y=0.
- Line period H_TOT cycles; frame period H_TOT*V_TOT cycles (defaults: 960 and 504000).
- HS high for H_ACT consecutive cycles, then low for H_BLK cycles. VS high for V_ACT*H_TOT consecutive cycles.
- Last RUN cycle before IDLE: X=H_TOT-1, Y=V_TOT-1, HS=VS=0.
- PIX is aligned with DE, with zero additional latency.

## Configuration
- LCD_SYNC_GEN_PATTERN_EN defined: PIX carries eight vertical colour bars of width BW=H_ACT/8 (integer). Bar index is min(X/BW, 7); the last bar absorbs the remainder. Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. PIX=0 whenever DE=0.
- LCD_SYNC_GEN_PATTERN_EN undefined: PIX is tied to 24'h000000 and no pattern logic is built. Timing outputs are identical in both builds.

## Test plan
- Reset then EN=1 at cycle 10 (defaults) → cycle 11: FRAME_START=1, X=0, Y=0, DE=1. FRAME_START recurs exactly every 504000 cycles.
- One full default frame → HS rises 525 times, each high for 800 cycles. VS is high for 480*960 = 460800 cycles. DE count is 384000.
- Drop EN at Y=100, then hold it low → frame completes. Last RUN cycle has X=959, Y=524; all outputs are 0 from the next cycle. Re-raising EN restarts at X=0, Y=0 one cycle later.
- EN pulsed low only at Y=200 and high again before the frame end → no gap; FRAME_START follows the previous one by exactly 504000 cycles.
- Assert RESET_N low at X=300, Y=50 → HS, VS, DE, X, Y are 0 before the next CLK edge. After release with EN=1, the raster restarts from X=0, Y=0.
- With LCD_SYNC_GEN_PATTERN_EN: X=0 → FFFFFF, X=99 → FFFFFF, X=100 → FFFF00, X=799 → 000000, X=800 → 0. Without the macro, PIX=0 throughout.

Source files
------------

// File: rtl/lcd_sync_gen_if.sv
// -----------------------------------------------------------------------------
// lcd_sync_gen_if
//
// Purpose : groups the run request and the raster outputs of lcd_sync_gen so
//           the generator and its consumers share one bundle.
//
// Signals : en          run request (level, driven by the controller)
//           hs          line valid
//           vs          frame valid
//           de          hs & vs
//           x, y        pixel / line position (12 bit)
//           frame_start one-cycle pulse on pixel (0,0)
//           pix         RGB888 {R,G,B}
//
// Modports: master - the generator (reads en, drives the raster)
//           slave  - the consumer / controller (drives en, reads the raster)
//
// Protocol: there is no valid/ready pair here. en is a level request that the
//           generator samples every cycle but only acts on at a frame boundary;
//           hs/vs/de are qualifiers that are never back-pressured, and every
//           raster output changes on the same clock edge.
// -----------------------------------------------------------------------------
interface lcd_sync_gen_if;
  logic        en;
  logic        hs;
  logic        vs;
  logic        de;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  logic [23:0] pix;

  modport master (
    input  en,
    output hs, vs, de, x, y, frame_start, pix
  );

  modport slave (
    output en,
    input  hs, vs, de, x, y, frame_start, pix
  );
endinterface

// File: rtl/lcd_sync_gen.sv
// -----------------------------------------------------------------------------
// lcd_sync_gen
//
// Purpose : free-running video timing source. Counts a pixel/line raster of
//           (H_ACT+H_BLK) x (V_ACT+V_BLK), starts and stops only on frame
//           boundaries and emits HS/VS/DE, X/Y, a frame-start strobe and an
//           optional colour-bar test pattern, all registered on the same edge.
//
// Ports   : clk_i    pixel clock, rising edge
//           rst_n_i  asynchronous active-low reset
//           bus      lcd_sync_gen_if.master (en in; hs, vs, de, x, y,
//                    frame_start, pix out)
//           run_o    debug view of the FSM: 1 while in RUN, 0 in IDLE
//
// Build option: LCD_SYNC_GEN_PATTERN_EN
//           defined   -> pix carries eight vertical colour bars during DE
//           undefined -> pix is tied to zero and no pattern logic exists
//
// Constraints: H_TOT = H_ACT+H_BLK and V_TOT = V_ACT+V_BLK must each be
//           <= 4096; H_BLK and V_BLK must each be >= 1.
// -----------------------------------------------------------------------------
module lcd_sync_gen #(
  parameter int H_ACT = 800,
  parameter int H_BLK = 160,
  parameter int V_ACT = 480,
  parameter int V_BLK = 45
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  lcd_sync_gen_if.master bus,
  output logic           run_o
);

  localparam int H_TOT = H_ACT + H_BLK;
  localparam int V_TOT = V_ACT + V_BLK;

  // All comparisons are done on 12-bit constants so that nothing in the
  // datapath grows past the counter width.
  localparam logic [11:0] H_LAST  = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOT - 1);
  localparam logic [11:0] H_ACT_W = 12'(H_ACT);
  localparam logic [11:0] V_ACT_W = 12'(V_ACT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;

  // ---------------------------------------------------------------------------
  // Next-state / counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;

    unique case (state_q)
      ST_IDLE: begin
        h_d = 12'd0;
        v_d = 12'd0;
        if (bus.en) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (h_q == H_LAST) begin
          h_d = 12'd0;
          if (v_q == V_LAST) begin
            // Frame end: the only cycle where en is acted on while running.
            // Either wrap straight into the next frame or drop to IDLE; the
            // counters are already back at zero in both cases.
            v_d = 12'd0;
            if (!bus.en) begin
              state_d = ST_IDLE;
            end
          end else begin
            v_d = v_q + 12'd1;
          end
        end else begin
          h_d = h_q + 12'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        h_d     = 12'd0;
        v_d     = 12'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the *next* counter values so that the flags land in
  // the same register stage as the counters that drive X/Y.
  // ---------------------------------------------------------------------------
  always_comb begin
    hs_d = 1'b0;
    vs_d = 1'b0;
    de_d = 1'b0;
    fs_d = 1'b0;
    if (state_d == ST_RUN) begin
      hs_d = (h_d < H_ACT_W);
      vs_d = (v_d < V_ACT_W);
      de_d = hs_d & vs_d;
      fs_d = (h_d == 12'd0) && (v_d == 12'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      h_q     <= 12'd0;
      v_q     <= 12'd0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  // In IDLE the counters are held at zero, so they double as X/Y directly.
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;
  assign bus.x           = h_q;
  assign bus.y           = v_q;
  assign run_o           = (state_q == ST_RUN);

`ifdef LCD_SYNC_GEN_PATTERN_EN
  // ---------------------------------------------------------------------------
  // Colour bars. Bar index is min(x / BW, 7), found with seven constant
  // threshold compares instead of a divider; the last bar absorbs the
  // remainder of H_ACT / 8.
  // ---------------------------------------------------------------------------
  localparam int BW = H_ACT / 8;

  logic [2:0]  bar_d;
  logic [23:0] pix_d, pix_q;

  always_comb begin
    bar_d = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_d >= 12'(k * BW)) begin
        bar_d = 3'(k);
      end
    end
  end

  always_comb begin
    pix_d = 24'h000000;
    if (de_d) begin
      unique case (bar_d)
        3'd0:    pix_d = 24'hFFFFFF;
        3'd1:    pix_d = 24'hFFFF00;
        3'd2:    pix_d = 24'h00FFFF;
        3'd3:    pix_d = 24'h00FF00;
        3'd4:    pix_d = 24'hFF00FF;
        3'd5:    pix_d = 24'hFF0000;
        3'd6:    pix_d = 24'h0000FF;
        default: pix_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pix_q <= 24'h000000;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign bus.pix = pix_q;
`else
  assign bus.pix = 24'h000000;
`endif

endmodule

// File: tb/tb_lcd_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_lcd_sync_gen
//
// Small raster (20 x 9, 180-cycle frame) so several frames fit in a short run.
// The reference model tracks a single linear pixel index p within the frame
// plus a running flag; X/Y and all flags are derived from p with plain
// division/modulo, independent of how the design counts.
// -----------------------------------------------------------------------------
module tb_lcd_sync_gen;

  localparam int H_ACT = 16;
  localparam int H_BLK = 4;
  localparam int V_ACT = 6;
  localparam int V_BLK = 3;
  localparam int H_TOT = H_ACT + H_BLK;
  localparam int V_TOT = V_ACT + V_BLK;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int BW    = H_ACT / 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic run;

  always #5 clk = ~clk;

  lcd_sync_gen_if bus ();

  lcd_sync_gen #(
    .H_ACT(H_ACT),
    .H_BLK(H_BLK),
    .V_ACT(V_ACT),
    .V_BLK(V_BLK)
  ) u_dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus),
    .run_o  (run)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  bit          m_run;
  int          m_p;
  logic [52:0] exp_q[$];
  int          n_cmp;
  int          n_fail;
  int          cyc;
  int          last_fs;

  // {run, hs, vs, de, frame_start, x, y, pix}
  function automatic logic [52:0] model_out();
    int x, y, bi;
    logic hs, vs, de, fs;
    logic [23:0] pix;
    if (!m_run) return '0;
    x   = m_p % H_TOT;
    y   = m_p / H_TOT;
    hs  = (x < H_ACT);
    vs  = (y < V_ACT);
    de  = hs & vs;
    fs  = (m_p == 0);
    pix = 24'h0;
`ifdef LCD_SYNC_GEN_PATTERN_EN
    bi = x / BW;
    if (bi > 7) bi = 7;
    if (de) pix = bars[bi];
`else
    bi = 0;
`endif
    return {1'b1, hs, vs, de, fs, 12'(x), 12'(y), pix};
  endfunction

  function automatic logic [52:0] obs();
    return {run, bus.hs, bus.vs, bus.de, bus.frame_start, bus.x, bus.y, bus.pix};
  endfunction

  // Advance the model by one clock edge using the en/reset seen at that edge.
  task automatic model_clock();
    if (!rst_n) begin
      m_run = 1'b0;
      m_p   = 0;
    end else if (!m_run) begin
      if (bus.en) begin
        m_run = 1'b1;
        m_p   = 0;
      end
    end else if (m_p == FRAME - 1) begin
      m_p = 0;
      if (!bus.en) m_run = 1'b0;
    end else begin
      m_p++;
    end
    exp_q.push_back(model_out());
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_clock();
    cyc++;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [52:0] e;
    bus.en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=0", obs());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL idle i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
  endtask

  task automatic test_start();
    logic [52:0] e;
    bus.en = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL start got=%h exp=%h", obs(), e);
    end
    n_cmp++;
    if (!(bus.frame_start === 1'b1 && bus.x === 12'd0 && bus.y === 12'd0 &&
          bus.de === 1'b1 && bus.hs === 1'b1 && bus.vs === 1'b1)) begin
      n_fail++;
      $display("FAIL start_first_pixel got fs=%b x=%0d y=%0d de=%b exp fs=1 x=0 y=0 de=1",
               bus.frame_start, bus.x, bus.y, bus.de);
    end
    last_fs = cyc;
  endtask

  task automatic test_frame_counts();
    logic [52:0] e;
    int rises, de_n, vs_n, run_len;
    bit prev;
    rises = 0; de_n = 0; vs_n = 0; run_len = 0; prev = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) begin
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL frame i=%0d got=%h exp=%h", i, obs(), e);
        end
      end
      if (bus.hs && !prev) rises++;
      if (bus.hs) begin
        run_len++;
      end else if (prev) begin
        n_cmp++;
        if (run_len != H_ACT) begin
          n_fail++;
          $display("FAIL hs_width got=%0d exp=%0d", run_len, H_ACT);
        end
        run_len = 0;
      end
      prev = bus.hs;
      if (bus.de) de_n++;
      if (bus.vs) vs_n++;
    end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL frame_wrap got=%h exp=%h", obs(), e);
    end
    n_cmp++;
    if (bus.frame_start !== 1'b1 || cyc - last_fs != FRAME) begin
      n_fail++;
      $display("FAIL fs_period got fs=%b period=%0d exp fs=1 period=%0d",
               bus.frame_start, cyc - last_fs, FRAME);
    end
    last_fs = cyc;
    n_cmp++;
    if (rises != V_TOT) begin
      n_fail++;
      $display("FAIL hs_rises got=%0d exp=%0d", rises, V_TOT);
    end
    n_cmp++;
    if (de_n != H_ACT * V_ACT) begin
      n_fail++;
      $display("FAIL de_count got=%0d exp=%0d", de_n, H_ACT * V_ACT);
    end
    n_cmp++;
    if (vs_n != V_ACT * H_TOT) begin
      n_fail++;
      $display("FAIL vs_count got=%0d exp=%0d", vs_n, V_ACT * H_TOT);
    end
  endtask

  // en wanders mid-frame but is high at the frame end: no gap expected.
  task automatic test_en_glitch();
    logic [52:0] e;
    for (int i = 0; i < FRAME; i++) begin
      bus.en = (m_p == FRAME - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL glitch i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    n_cmp++;
    if (bus.frame_start !== 1'b1 || cyc - last_fs != FRAME) begin
      n_fail++;
      $display("FAIL glitch_no_gap got fs=%b period=%0d exp fs=1 period=%0d",
               bus.frame_start, cyc - last_fs, FRAME);
    end
    last_fs = cyc;
  endtask

  task automatic test_stop();
    logic [52:0] e;
    bit saw_last;
    saw_last = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < FRAME && !(m_run && m_p / H_TOT == 2); i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL stop_pre i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    bus.en = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL stop i=%0d got=%h exp=%h", i, obs(), e);
      end
      if (bus.x === 12'(H_TOT - 1) && bus.y === 12'(V_TOT - 1)) begin
        saw_last = 1'b1;
        n_cmp++;
        if (bus.hs !== 1'b0 || bus.vs !== 1'b0 || bus.de !== 1'b0) begin
          n_fail++;
          $display("FAIL stop_last got hs=%b vs=%b de=%b exp 0 0 0", bus.hs, bus.vs, bus.de);
        end
      end
    end
    n_cmp++;
    if (!saw_last || obs() !== '0) begin
      n_fail++;
      $display("FAIL stop_idle got last_seen=%b out=%h exp last_seen=1 out=0", saw_last, obs());
    end
    bus.en = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs() !== e || bus.frame_start !== 1'b1 || bus.x !== 12'd0 || bus.y !== 12'd0) begin
      n_fail++;
      $display("FAIL restart got=%h exp=%h", obs(), e);
    end
    last_fs = cyc;
  endtask

  task automatic test_async_reset();
    logic [52:0] e;
    bus.en = 1'b1;
    for (int i = 0; i < FRAME && !(m_run && m_p == 3 * H_TOT + 5); i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL arst_pre i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    m_run = 1'b0;
    m_p   = 0;
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate got=%h exp=0", obs());
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL arst_hold i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    #2 rst_n = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs() !== e || bus.frame_start !== 1'b1 || bus.x !== 12'd0 || bus.y !== 12'd0) begin
      n_fail++;
      $display("FAIL arst_restart got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_random();
    logic [52:0] e;
    for (int i = 0; i < 1500; i++) begin
      if (m_run && m_p != FRAME - 1) bus.en = ($urandom_range(0, 3) != 0);
      else                           bus.en = 1'($urandom_range(0, 1));
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL random i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    cyc     = 0;
    last_fs = 0;
    m_run   = 1'b0;
    m_p     = 0;
    bus.en  = 1'b0;

    test_reset();
    test_start();
    test_frame_counts();
    test_en_glitch();
    test_stop();
    test_async_reset();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
